// File: rtl/bus_irq_pkg.sv
// Shared constants for bus_irq_timer: register offsets, CTRL field positions,
// interrupt source indices and the interrupt vector encoder.
package bus_irq_pkg;

    localparam logic [2:0] OFF_TLO  = 3'd0;
    localparam logic [2:0] OFF_THI  = 3'd1;
    localparam logic [2:0] OFF_CNTL = 3'd2;
    localparam logic [2:0] OFF_CNTH = 3'd3;
    localparam logic [2:0] OFF_CTRL = 3'd4;
    localparam logic [2:0] OFF_IER  = 3'd5;
    localparam logic [2:0] OFF_IFR  = 3'd6;
    localparam logic [2:0] OFF_IVEC = 3'd7;

    localparam logic [2:0] CTRL_RUN    = 3'd0;
    localparam logic [2:0] CTRL_AUTO   = 3'd1;
    localparam logic [2:0] CTRL_PS_LSB = 3'd4;
    localparam logic [2:0] CTRL_PS_MSB = 3'd7;

    localparam int unsigned N_SRC = 32'd5;

    localparam logic [2:0] IRQ_EXT0  = 3'd0;
    localparam logic [2:0] IRQ_EXT1  = 3'd1;
    localparam logic [2:0] IRQ_EXT2  = 3'd2;
    localparam logic [2:0] IRQ_EXT3  = 3'd3;
    localparam logic [2:0] IRQ_TIMER = 3'd4;

    localparam logic [7:0] IVEC_NONE = 8'h80;

    // Highest index wins: timer first, then external lines 3 down to 0.
    function automatic logic [7:0] ivec_encode(input logic [N_SRC-1:0] pend);
        logic [7:0] vec;
        if (pend[IRQ_TIMER])     vec = {5'd0, IRQ_TIMER};
        else if (pend[IRQ_EXT3]) vec = {5'd0, IRQ_EXT3};
        else if (pend[IRQ_EXT2]) vec = {5'd0, IRQ_EXT2};
        else if (pend[IRQ_EXT1]) vec = {5'd0, IRQ_EXT1};
        else if (pend[IRQ_EXT0]) vec = {5'd0, IRQ_EXT0};
        else                     vec = IVEC_NONE;
        return vec;
    endfunction

endpackage

// File: rtl/irq_edge_sync.sv
// One external interrupt line: multi-flop synchronizer followed by a
// single-cycle rising-edge pulse.
module irq_edge_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic pulse
);

    logic [STAGES-1:0] sync_r;
    logic              prev_r;

    // Synchronizer chain plus the delayed copy used for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_r <= {STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[STAGES-2:0], async_in};
            prev_r <= sync_r[STAGES-1];
        end
    end

    assign pulse = sync_r[STAGES-1] & ~prev_r;

endmodule

// File: rtl/bus_irq_timer.sv
// Memory-mapped 16-bit down-counter and 5-source interrupt controller on the
// 65C02 core bus. Optional prescaler enabled by BUS_IRQ_TIMER_PRESCALE_EN.
module bus_irq_timer
    import bus_irq_pkg::*;
#(
    parameter logic [15:0] BASE        = 16'hFE00,
    parameter int          N_EXT       = 4,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] AB,
    input  logic [7:0]  DO,
    input  logic        WE,
    input  logic [3:0]  ext_irq,
    output logic [7:0]  rdata,
    output logic        rd_en,
    output logic        irq
);

`ifdef BUS_IRQ_TIMER_PRESCALE_EN
    localparam logic [7:0] CTRL_WMASK = 8'hF3;
`else
    localparam logic [7:0] CTRL_WMASK = 8'h03;
`endif

    logic [15:0] reload_r;
    logic [15:0] counter_r;
    logic [7:0]  shadow_r;
    logic [7:0]  ctrl_r;
    logic [4:0]  ier_r;
    logic [4:0]  ifr_r;

    logic        hit_s, wr_s, rd_s, thi_wr_s;
    logic [2:0]  off_s;
    logic        run_s, auto_s, tick_s;
    logic        timer_set_s, run_clr_s;
    logic [15:0] counter_nxt_s;
    logic [4:0]  ifr_nxt_s;
    logic [7:0]  ctrl_nxt_s;
    logic [7:0]  rd_data_s;
    logic [3:0]  ext_pulse_s;

    assign hit_s    = (AB[15:3] == BASE[15:3]);
    assign off_s    = AB[2:0];
    assign wr_s     = hit_s & WE;
    assign rd_s     = hit_s & ~WE;
    assign thi_wr_s = wr_s & (off_s == OFF_THI);
    assign run_s    = ctrl_r[CTRL_RUN];
    assign auto_s   = ctrl_r[CTRL_AUTO];

    for (genvar i = 0; i < 4; i++) begin : g_ext
        if (i < N_EXT) begin : g_used
            irq_edge_sync #(.STAGES(SYNC_STAGES)) u_sync (
                .clk      (clk),
                .reset_n  (reset_n),
                .async_in (ext_irq[i]),
                .pulse    (ext_pulse_s[i])
            );
        end else begin : g_tied
            assign ext_pulse_s[i] = 1'b0;
        end
    end

`ifdef BUS_IRQ_TIMER_PRESCALE_EN
    logic [7:0] prescale_r;
    logic [3:0] ps_s;
    logic [7:0] ps_mask_s;

    // Tick whenever the low PS bits of the free-running prescaler are all ones.
    always_comb begin
        ps_s      = (ctrl_r[CTRL_PS_MSB:CTRL_PS_LSB] > 4'd8) ? 4'd8
                                                             : ctrl_r[CTRL_PS_MSB:CTRL_PS_LSB];
        ps_mask_s = 8'hFF >> (4'd8 - ps_s);
        tick_s    = ((prescale_r & ps_mask_s) == ps_mask_s);
    end

    // Prescaler restarts on a reload and stays cleared while stopped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prescale_r <= 8'd0;
        end else if (thi_wr_s || !run_s) begin
            prescale_r <= 8'd0;
        end else begin
            prescale_r <= prescale_r + 8'd1;
        end
    end
`else
    assign tick_s = 1'b1;
`endif

    // Counter next state; a THI write overrides any expiry in the same cycle.
    always_comb begin
        counter_nxt_s = counter_r;
        timer_set_s   = 1'b0;
        run_clr_s     = 1'b0;
        if (thi_wr_s) begin
            counter_nxt_s = {DO, reload_r[7:0]};
        end else if (run_s && tick_s) begin
            if (counter_r != 16'd0) begin
                counter_nxt_s = counter_r - 16'd1;
            end else begin
                timer_set_s = 1'b1;
                if (auto_s) begin
                    counter_nxt_s = reload_r;
                end else begin
                    run_clr_s = 1'b1;
                end
            end
        end else begin
            counter_nxt_s = counter_r;
        end
    end

    // Flag and control updates: new events beat W1C, CPU CTRL write beats auto-stop.
    always_comb begin
        ifr_nxt_s  = ifr_r;
        ctrl_nxt_s = ctrl_r;
        if (wr_s && (off_s == OFF_IFR)) begin
            ifr_nxt_s = ifr_r & ~DO[4:0];
        end else begin
            ifr_nxt_s = ifr_r;
        end
        ifr_nxt_s = (ifr_nxt_s | {timer_set_s, ext_pulse_s}) & ~{thi_wr_s, 4'b0000};
        if (wr_s && (off_s == OFF_CTRL)) begin
            ctrl_nxt_s = DO & CTRL_WMASK;
        end else if (run_clr_s) begin
            ctrl_nxt_s = ctrl_r & ~(8'h01 << CTRL_RUN);
        end else begin
            ctrl_nxt_s = ctrl_r;
        end
    end

    // Read data mux for the addressed register.
    always_comb begin
        rd_data_s = 8'h00;
        case (off_s)
            OFF_TLO:  rd_data_s = reload_r[7:0];
            OFF_THI:  rd_data_s = reload_r[15:8];
            OFF_CNTL: rd_data_s = counter_r[7:0];
            OFF_CNTH: rd_data_s = shadow_r;
            OFF_CTRL: rd_data_s = ctrl_r;
            OFF_IER:  rd_data_s = {3'b000, ier_r};
            OFF_IFR:  rd_data_s = {3'b000, ifr_r};
            OFF_IVEC: rd_data_s = ivec_encode(ifr_r & ier_r);
            default:  rd_data_s = 8'h00;
        endcase
    end

    // Register file, counter, read port and interrupt output.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            reload_r  <= 16'd0;
            counter_r <= 16'd0;
            shadow_r  <= 8'd0;
            ctrl_r    <= 8'd0;
            ier_r     <= 5'd0;
            ifr_r     <= 5'd0;
            rdata     <= 8'd0;
            rd_en     <= 1'b0;
            irq       <= 1'b0;
        end else begin
            counter_r <= counter_nxt_s;
            ifr_r     <= ifr_nxt_s;
            ctrl_r    <= ctrl_nxt_s;
            irq       <= |(ifr_r & ier_r);
            if (wr_s && (off_s == OFF_TLO)) reload_r[7:0]  <= DO;
            if (thi_wr_s)                   reload_r[15:8] <= DO;
            if (wr_s && (off_s == OFF_IER)) ier_r          <= DO[4:0];
            if (rd_s && (off_s == OFF_CNTL)) shadow_r      <= counter_r[15:8];
            if (rd_s) begin
                rdata <= rd_data_s;
                rd_en <= 1'b1;
            end else begin
                rd_en <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_bus_irq_timer.sv
// Directed, table-driven bench for bus_irq_timer; prescaler scenario runs
// only when BUS_IRQ_TIMER_PRESCALE_EN is defined.
module tb_bus_irq_timer;

    localparam logic [15:0] BASE = 16'hFE00;
    localparam logic [15:0] IDLE = 16'h0000;
`ifdef BUS_IRQ_TIMER_PRESCALE_EN
    localparam logic [7:0] CTRL_FC_EXP = 8'hF0;
`else
    localparam logic [7:0] CTRL_FC_EXP = 8'h00;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] AB;
    logic [7:0]  DO;
    logic        WE;
    logic [3:0]  ext_irq;
    logic [7:0]  rdata;
    logic        rd_en;
    logic        irq;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [2:0] off;
        logic [7:0] exp;
    } rd_vec_t;

    typedef struct {
        string      name;
        logic [2:0] off;
        logic [7:0] wdata;
        logic [7:0] exp;
    } rw_vec_t;

    rd_vec_t rd_tab [8];
    rw_vec_t rw_tab [6];

    bus_irq_timer #(.BASE(BASE), .N_EXT(4), .SYNC_STAGES(2)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .AB      (AB),
        .DO      (DO),
        .WE      (WE),
        .ext_irq (ext_irq),
        .rdata   (rdata),
        .rd_en   (rd_en),
        .irq     (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    // Called at a negedge; the write lands on the next posedge; returns at the following negedge.
    task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
        AB = BASE | {13'd0, off};
        WE = 1'b1;
        DO = d;
        @(negedge clk);
        AB = IDLE;
        WE = 1'b0;
        DO = 8'h00;
    endtask

    // Called at a negedge; returns the captured data at the following negedge.
    task automatic bus_read(input logic [2:0] off, output logic [7:0] d, output logic en);
        AB = BASE | {13'd0, off};
        WE = 1'b0;
        @(negedge clk);
        d  = rdata;
        en = rd_en;
        AB = IDLE;
    endtask

    task automatic read_check(input string name, input logic [2:0] off, input logic [7:0] exp);
        logic [7:0] d;
        logic       en;
        bus_read(off, d, en);
        check({name, "_en"}, {7'd0, en}, 8'h01);
        check(name, d, exp);
    endtask

    initial begin
        logic [7:0] d;
        logic       en;

        for (int i = 0; i < 8; i++) begin
            rd_tab[i].off = 3'(i);
            rd_tab[i].exp = (i == 7) ? 8'h80 : 8'h00;
        end
        rw_tab[0] = '{"rw_tlo",  3'd0, 8'hA5, 8'hA5};
        rw_tab[1] = '{"rw_ier",  3'd5, 8'hFF, 8'h1F};
        rw_tab[2] = '{"rw_ifr",  3'd6, 8'hFF, 8'h00};
        rw_tab[3] = '{"rw_ctrl", 3'd4, 8'hFC, CTRL_FC_EXP};
        rw_tab[4] = '{"rw_cntl", 3'd2, 8'h55, 8'h00};
        rw_tab[5] = '{"rw_ivec", 3'd7, 8'h12, 8'h80};

        reset_n = 1'b0;
        AB      = IDLE;
        DO      = 8'h00;
        WE      = 1'b0;
        ext_irq = 4'b0000;
        repeat (2) @(negedge clk);
        check("rst_rdata", rdata, 8'h00);
        check("rst_rd_en", {7'd0, rd_en}, 8'h00);
        check("rst_irq", {7'd0, irq}, 8'h00);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset values of all eight offsets; rd_en lasts one cycle.
        for (int i = 0; i < 8; i++) begin
            bus_read(rd_tab[i].off, d, en);
            check($sformatf("rst_rd%0d_en", i), {7'd0, en}, 8'h01);
            check($sformatf("rst_rd%0d", i), d, rd_tab[i].exp);
            @(negedge clk);
            check($sformatf("rst_rd%0d_en_drop", i), {7'd0, rd_en}, 8'h00);
        end
        check("rst_irq_idle", {7'd0, irq}, 8'h00);

        // Write/readback masks and read-only offsets.
        for (int i = 0; i < 6; i++) begin
            bus_write(rw_tab[i].off, rw_tab[i].wdata);
            read_check(rw_tab[i].name, rw_tab[i].off, rw_tab[i].exp);
        end
        bus_write(3'd4, 8'h00);
        bus_write(3'd5, 8'h00);

        // Auto-reload timer with reload 3: flag every 4 ticks.
        bus_write(3'd0, 8'h03);
        bus_write(3'd1, 8'h00);
        bus_write(3'd5, 8'h10);
        bus_write(3'd4, 8'h03);
        repeat (3) @(negedge clk);
        check("tmr_irq_pre", {7'd0, irq}, 8'h00);
        read_check("tmr_ifr_pre", 3'd6, 8'h00);
        check("tmr_irq_lag", {7'd0, irq}, 8'h00);
        read_check("tmr_ifr_set", 3'd6, 8'h10);
        check("tmr_irq_rise", {7'd0, irq}, 8'h01);
        repeat (2) @(negedge clk);
        bus_write(3'd6, 8'h10);
        read_check("tmr_set_wins", 3'd6, 8'h10);
        check("tmr_irq_held", {7'd0, irq}, 8'h01);
        bus_write(3'd6, 8'h10);
        check("tmr_irq_fall_lag", {7'd0, irq}, 8'h01);
        @(negedge clk);
        check("tmr_irq_fall", {7'd0, irq}, 8'h00);
        read_check("tmr_ifr_clr", 3'd6, 8'h00);
        bus_write(3'd4, 8'h00);
        bus_write(3'd6, 8'h1F);
        bus_write(3'd5, 8'h04);
        read_check("tmr_stop_ifr", 3'd6, 8'h00);

        // External line 2: synchronizer latency and single set on a held level.
        ext_irq = 4'b0100;
        repeat (2) @(negedge clk);
        read_check("ext_ifr_pre", 3'd6, 8'h00);
        read_check("ext_ifr_set", 3'd6, 8'h04);
        check("ext_irq_out", {7'd0, irq}, 8'h01);
        bus_write(3'd6, 8'h04);
        ext_irq = 4'b0000;
        repeat (3) @(negedge clk);
        read_check("ext_once", 3'd6, 8'h00);
        ext_irq = 4'b0100;
        repeat (5) @(negedge clk);
        ext_irq = 4'b0000;

        // Non-auto timer expiring from 0 alongside the pending external flag.
        bus_write(3'd0, 8'h00);
        bus_write(3'd1, 8'h00);
        bus_write(3'd5, 8'h14);
        bus_write(3'd4, 8'h01);
        read_check("ivec_ext", 3'd7, 8'h02);
        read_check("ivec_timer", 3'd7, 8'h04);
        read_check("run_autoclr", 3'd4, 8'h00);
        read_check("ifr_both", 3'd6, 8'h14);
        bus_write(3'd6, 8'hFF);
        bus_write(3'd5, 8'h00);

        // CNTH returns the high byte latched by the CNTL read.
        bus_write(3'd0, 8'h34);
        bus_write(3'd1, 8'h12);
        read_check("snap_lo_idle", 3'd2, 8'h34);
        read_check("snap_hi_idle", 3'd3, 8'h12);
        bus_write(3'd4, 8'h01);
        read_check("snap_lo_run", 3'd2, 8'h34);
        repeat (59) @(negedge clk);
        read_check("snap_hi_run", 3'd3, 8'h12);
        read_check("snap_lo_run2", 3'd2, 8'hF7);
        read_check("snap_hi_run2", 3'd3, 8'h11);
        bus_write(3'd4, 8'h00);

`ifdef BUS_IRQ_TIMER_PRESCALE_EN
        // PS=2, reload 1, auto: expiry every 8 clocks.
        bus_write(3'd0, 8'h01);
        bus_write(3'd1, 8'h00);
        bus_write(3'd6, 8'hFF);
        bus_write(3'd5, 8'h10);
        bus_write(3'd4, 8'h23);
        repeat (7) @(negedge clk);
        read_check("ps_ifr_pre", 3'd6, 8'h00);
        read_check("ps_ifr_set", 3'd6, 8'h10);
        bus_write(3'd6, 8'h10);
        repeat (5) @(negedge clk);
        read_check("ps_ifr_pre2", 3'd6, 8'h00);
        read_check("ps_ifr_set2", 3'd6, 8'h10);
        bus_write(3'd4, 8'h00);
        bus_write(3'd6, 8'hFF);
        bus_write(3'd5, 8'h00);
`endif

        // Asynchronous reset in the middle of a running count.
        bus_write(3'd0, 8'h05);
        bus_write(3'd1, 8'h00);
        bus_write(3'd5, 8'h10);
        bus_write(3'd4, 8'h03);
        repeat (10) @(negedge clk);
        check("mid_irq_before", {7'd0, irq}, 8'h01);
        read_check("mid_ifr_before", 3'd6, 8'h10);
        #1 reset_n = 1'b0;
        #1;
        check("mid_rst_rdata", rdata, 8'h00);
        check("mid_rst_rd_en", {7'd0, rd_en}, 8'h00);
        check("mid_rst_irq", {7'd0, irq}, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_rst_irq", {7'd0, irq}, 8'h00);
        read_check("post_rst_ctrl", 3'd4, 8'h00);
        read_check("post_rst_ifr", 3'd6, 8'h00);
        read_check("post_rst_cntl", 3'd2, 8'h00);
        repeat (6) @(negedge clk);
        check("post_rst_irq_late", {7'd0, irq}, 8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
